instr_fetch_unit: RTL and testbench

//  Fetch stage that drives the byte-wide unified memory: reads four consecutive bytes
//  at the program counter, assembles them big-endian into a 32-bit instruction word,
//  and hands it to the control FSM with a one-cycle valid pulse.

---
 rtl/instr_fetch_unit.sv | 95 +++++++++
 tb/tb_instr_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads four bytes at the PC from byte-wide memory,
// packs them big-endian into one word, and owns PC sequencing and redirects.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [7:0]        MemData,
  output logic              MemRead,
  output logic [ADDR_W-1:0] Address,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_ipc;
  logic [31:0]       r_instr;
  logic [23:0]       r_shadow;
  logic              r_vld;
  logic [ADDR_W-1:0] w_ofs;

  always_comb begin
    w_ofs = '0;
    case (r_state)
      S_B1:    w_ofs = ADDR_W'(1);
      S_B2:    w_ofs = ADDR_W'(2);
      S_B3:    w_ofs = ADDR_W'(3);
      default: w_ofs = '0;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign MemRead     = busy;
  assign Address     = busy ? (r_base + w_ofs) : r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_ipc;
  assign instr_valid = r_vld;

  always_ff @(posedge ph1) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_base   <= '0;
      r_ipc    <= '0;
      r_instr  <= '0;
      r_shadow <= '0;
      r_vld    <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (r_state == S_IDLE) begin
        if (redirect_valid) begin
          r_pc <= redirect_pc;
          if (fetch_req) begin
            r_base  <= redirect_pc;
            r_state <= S_B0;
          end
        end else if (fetch_req) begin
          r_base  <= r_pc;
          r_state <= S_B0;
        end
      end else if (redirect_valid) begin
        // Redirect aborts an in-flight fetch, even on its final byte.
        r_pc    <= redirect_pc;
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_B0: begin r_shadow[23:16] <= MemData; r_state <= S_B1; end
          S_B1: begin r_shadow[15:8]  <= MemData; r_state <= S_B2; end
          S_B2: begin r_shadow[7:0]   <= MemData; r_state <= S_B3; end
          S_B3: begin
            r_instr <= {r_shadow, MemData};
            r_ipc   <= r_base;
            r_pc    <= r_base + ADDR_W'(4);
            r_vld   <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: byte memory model plus a word-level fetch model
// (PC, last instruction) exercised by directed and randomized scenarios.
module tb_instr_fetch_unit;

  logic        ph1 = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [7:0]  MemData;
  logic        MemRead;
  logic [7:0]  Address;
  logic [31:0] instr;
  logic        instr_valid;
  logic [7:0]  instr_pc;
  logic [7:0]  pc;
  logic        busy;

  logic [7:0]  mem [256];
  int          n_vec = 0;
  int          n_err = 0;

  // Word-level reference state
  logic [7:0]  m_pc;
  logic [31:0] m_instr;
  logic [7:0]  m_ipc;

  assign MemData = MemRead ? mem[Address] : 8'h00;

  always #5 ph1 = ~ph1;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .ph1(ph1), .reset(reset), .fetch_req(fetch_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .MemData(MemData), .MemRead(MemRead), .Address(Address),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .pc(pc), .busy(busy)
  );

  task automatic step();
    @(posedge ph1);
    #1;
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] base);
    logic [7:0] a0, a1, a2, a3;
    a0 = base; a1 = base + 8'd1; a2 = base + 8'd2; a3 = base + 8'd3;
    return {mem[a0], mem[a1], mem[a2], mem[a3]};
  endfunction

  // One fetch; returns the observed bus trace and the result cycle values.
  task automatic drive_fetch(input bit redir, input logic [7:0] rpc,
                             output logic [7:0] addr [4], output logic [3:0] rd,
                             output logic vld, output logic [31:0] ins,
                             output logic [7:0] ipc, output logic [7:0] npc,
                             output logic vld_after);
    fetch_req = 1'b1; redirect_valid = redir; redirect_pc = rpc;
    step();
    fetch_req = 1'b0; redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr[k] = Address; rd[k] = MemRead;
      step();
    end
    vld = instr_valid; ins = instr; ipc = instr_pc; npc = pc;
    step();
    vld_after = instr_valid;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
    m_pc = 8'h00; m_instr = '0; m_ipc = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (pc !== 8'h00) begin n_err++; $display("FAIL reset_pc got %h want 00", pc); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", instr); end
    n_vec++; if ({instr_valid, busy, MemRead} !== 3'b000) begin n_err++; $display("FAIL reset_ctl got %b want 000", {instr_valid, busy, MemRead}); end
    n_vec++; if (instr_pc !== 8'h00) begin n_err++; $display("FAIL reset_ipc got %h want 00", instr_pc); end
  endtask

  task automatic test_single_fetch();
    logic [7:0] addr [4]; logic [3:0] rd; logic v, va; logic [31:0] ins; logic [7:0] ipc, npc;
    do_reset();
    drive_fetch(1'b0, 8'h00, addr, rd, v, ins, ipc, npc, va);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (addr[k] !== 8'(k) || rd[k] !== 1'b1) begin n_err++; $display("FAIL single_addr%0d got %h/%b want %h/1", k, addr[k], rd[k], 8'(k)); end
    end
    n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", v); end
    n_vec++; if (ins !== 32'h20030008) begin n_err++; $display("FAIL single_instr got %h want 20030008", ins); end
    n_vec++; if (ipc !== 8'h00 || npc !== 8'h04) begin n_err++; $display("FAIL single_pc got ipc %h pc %h want 00 04", ipc, npc); end
    n_vec++; if (va !== 1'b0) begin n_err++; $display("FAIL single_pulse_width got %b want 0", va); end
    m_pc = 8'h04; m_instr = 32'h20030008; m_ipc = 8'h00;
  endtask

  task automatic test_back_to_back();
    int pulses [$];
    logic [31:0] ins_q [$];
    logic [7:0]  ipc_q [$];
    do_reset();
    fetch_req = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (instr_valid) begin pulses.push_back(c); ins_q.push_back(instr); ipc_q.push_back(instr_pc); end
    end
    fetch_req = 1'b0;
    for (int c = 16; c <= 22; c++) begin
      step();
      if (instr_valid) begin pulses.push_back(c); ins_q.push_back(instr); ipc_q.push_back(instr_pc); end
    end
    n_vec++;
    if (pulses.size() != 3) begin
      n_err++; $display("FAIL b2b_count got %0d want 3", pulses.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (pulses[i] != 5 * (i + 1)) begin n_err++; $display("FAIL b2b_cycle%0d got %0d want %0d", i, pulses[i], 5 * (i + 1)); end
        n_vec++;
        if (ipc_q[i] !== 8'(4 * i) || ins_q[i] !== word_at(8'(4 * i))) begin
          n_err++; $display("FAIL b2b_word%0d got %h@%h want %h@%h", i, ins_q[i], ipc_q[i], word_at(8'(4 * i)), 8'(4 * i));
        end
      end
      n_vec++; if (ins_q[2] !== 32'h2005FFFF) begin n_err++; $display("FAIL b2b_word2_const got %h want 2005ffff", ins_q[2]); end
    end
    m_pc = 8'h0C; m_instr = word_at(8'h08); m_ipc = 8'h08;
  endtask

  task automatic test_redirect_fetch();
    logic [7:0] addr [4]; logic [3:0] rd; logic v, va; logic [31:0] ins; logic [7:0] ipc, npc;
    drive_fetch(1'b1, 8'h20, addr, rd, v, ins, ipc, npc, va);
    n_vec++; if (addr[0] !== 8'h20 || addr[3] !== 8'h23) begin n_err++; $display("FAIL redir_addr got %h..%h want 20..23", addr[0], addr[3]); end
    n_vec++; if (v !== 1'b1 || ins !== 32'hA00400FF) begin n_err++; $display("FAIL redir_instr got %b %h want 1 a00400ff", v, ins); end
    n_vec++; if (npc !== 8'h24 || ipc !== 8'h20) begin n_err++; $display("FAIL redir_pc got pc %h ipc %h want 24 20", npc, ipc); end
    m_pc = 8'h24; m_instr = 32'hA00400FF; m_ipc = 8'h20;
  endtask

  // Abort at stage k (0..3) with a redirect; k=3 is the final-byte edge.
  task automatic test_abort(input int k, input logic [7:0] tgt);
    logic seen;
    seen = 1'b0;
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    for (int s = 0; s < k; s++) step();
    redirect_valid = 1'b1; redirect_pc = tgt;
    step();
    redirect_valid = 1'b0;
    seen = instr_valid;
    n_vec++; if (busy !== 1'b0 || MemRead !== 1'b0) begin n_err++; $display("FAIL abort%0d_busy got %b want 0", k, busy); end
    n_vec++; if (pc !== tgt) begin n_err++; $display("FAIL abort%0d_pc got %h want %h", k, pc, tgt); end
    n_vec++; if (instr !== m_instr || instr_pc !== m_ipc) begin n_err++; $display("FAIL abort%0d_instr got %h want %h", k, instr, m_instr); end
    step();
    seen = seen | instr_valid;
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort%0d_valid got %b want 0", k, seen); end
    m_pc = tgt;
  endtask

  task automatic test_wrap();
    logic [7:0] addr [4]; logic [3:0] rd; logic v, va; logic [31:0] ins; logic [7:0] ipc, npc;
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;
    drive_fetch(1'b1, 8'hFE, addr, rd, v, ins, ipc, npc, va);
    n_vec++;
    if ({addr[0], addr[1], addr[2], addr[3]} !== 32'hFEFF0001) begin
      n_err++; $display("FAIL wrap_addr got %h %h %h %h want fe ff 00 01", addr[0], addr[1], addr[2], addr[3]);
    end
    n_vec++; if (v !== 1'b1 || ins !== 32'hAABBCCDD) begin n_err++; $display("FAIL wrap_instr got %b %h want 1 aabbccdd", v, ins); end
    n_vec++; if (npc !== 8'h02) begin n_err++; $display("FAIL wrap_pc got %h want 02", npc); end
    m_pc = 8'h02; m_instr = 32'hAABBCCDD; m_ipc = 8'hFE;
  endtask

  task automatic test_reset_midfetch();
    logic seen;
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    step(); step();
    n_vec++; if (Address !== 8'(m_pc + 8'd2)) begin n_err++; $display("FAIL rstmid_b2addr got %h want %h", Address, 8'(m_pc + 8'd2)); end
    reset = 1'b1; step(); reset = 1'b0;
    seen = instr_valid;
    n_vec++; if (busy !== 1'b0 || MemRead !== 1'b0) begin n_err++; $display("FAIL rstmid_idle got %b%b want 00", busy, MemRead); end
    n_vec++; if (pc !== 8'h00 || instr !== 32'h0) begin n_err++; $display("FAIL rstmid_state got pc %h instr %h want 00 0", pc, instr); end
    step();
    seen = seen | instr_valid;
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", seen); end
    m_pc = 8'h00; m_instr = '0; m_ipc = 8'h00;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      bit redir, abort, done;
      int ak;
      logic [7:0] rpc, apc, base;
      redir = ($urandom_range(0, 2) == 0);
      rpc   = 8'($urandom);
      abort = ($urandom_range(0, 3) == 0);
      ak    = $urandom_range(0, 3);
      apc   = 8'($urandom);
      base  = redir ? rpc : m_pc;
      done  = 1'b0;
      fetch_req = 1'b1; redirect_valid = redir; redirect_pc = rpc;
      step();
      fetch_req = 1'b0; redirect_valid = 1'b0;
      for (int k = 0; k < 4 && !done; k++) begin
        n_vec++;
        if (Address !== 8'(base + 8'(k)) || MemRead !== 1'b1) begin
          n_err++; $display("FAIL rand%0d_addr%0d got %h/%b want %h/1", it, k, Address, MemRead, 8'(base + 8'(k)));
        end
        if (abort && k == ak) begin
          redirect_valid = 1'b1; redirect_pc = apc;
          done = 1'b1;
        end
        step();
        redirect_valid = 1'b0;
      end
      if (abort) begin
        n_vec++;
        if (instr_valid !== 1'b0 || pc !== apc || instr !== m_instr || busy !== 1'b0) begin
          n_err++; $display("FAIL rand%0d_abort got v%b pc %h instr %h want v0 pc %h instr %h", it, instr_valid, pc, instr, apc, m_instr);
        end
        m_pc = apc;
      end else begin
        m_instr = word_at(base); m_ipc = base; m_pc = base + 8'd4;
        n_vec++;
        if (instr_valid !== 1'b1 || instr !== m_instr || instr_pc !== m_ipc || pc !== m_pc) begin
          n_err++; $display("FAIL rand%0d_fetch got v%b %h@%h pc %h want v1 %h@%h pc %h", it, instr_valid, instr, instr_pc, pc, m_instr, m_ipc, m_pc);
        end
      end
      step();
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rand%0d_pulse got %b want 0", it, instr_valid); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    {mem[0], mem[1], mem[2], mem[3]}       = 32'h20030008;
    {mem[4], mem[5], mem[6], mem[7]}       = 32'h20040001;
    {mem[8], mem[9], mem[10], mem[11]}     = 32'h2005FFFF;
    {mem[32], mem[33], mem[34], mem[35]}   = 32'hA00400FF;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_redirect_fetch();
    test_abort(1, 8'h1C);
    test_abort(3, 8'h40);
    test_abort(0, 8'h60);
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
